seg7_scan_capture: RTL and testbench
====================================

Name: seg7_scan_capture

Overview:
- Reader for multiplexed 7-segment displays: samples a time-multiplexed segment bus plus active-low digit strobes (as driven onto a front-panel display).
- Qualifies each pattern for stability, decodes it back to a BCD digit, stores one value per digit position, and flags a completed frame.
- Used on the k30p board to monitor or self-check the display path.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digit positions (1..8).
- STABLE_CYCLES, 8, consecutive identical samples required before capture (2..255).

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- segments_n  input  7  active-low segments; bit0=a ... bit6=g (0 = lit).
- digit_n  input  NUM_DIGITS  active-low digit strobes; bit i selects position i.
- values  output  4*NUM_DIGITS  captured BCD digits; position i at bits [4i+3:4i].
- blank  output  NUM_DIGITS  bit i set when position i last captured all-segments-off.
- frame_valid  output  1  one-cycle pulse when every position has been captured since the last pulse.
- error  output  1  one-cycle pulse when a stable, selected pattern is not a legal glyph.
- error_digit  output  3  position index of the most recent error; held until the next error.

Behaviour:
- Reset: the interface is one clock, with synchronous, active-high reset. On reset:
  - values=0, blank=all 1s, frame_valid=0, error=0, error_digit=0.
  - Internal seen mask, stability counter, captured flag and synchronizers cleared to idle (segments_n=7'h7F, digit_n=all 1s).
- Input synchronization: segments_n and digit_n pass through a 2-flop synchronizer; all logic below uses synchronized sample S.
- Selection valid: exactly one bit of digit_n is low.
  - Zero or more than one low: counter=0 and captured=0; no capture.
- Stability counter (8 bits):
  - Resets to 0 when S differs from the previous S.
  - Otherwise increments, saturating at STABLE_CYCLES.
- Capture event: fires exactly once per stable window, on the edge where the counter reaches STABLE_CYCLES-1 with captured=0. That edge sets captured=1; captured clears when S changes.
  - Latency: an input held constant appears on outputs exactly 2+STABLE_CYCLES clocks after it was applied.
- Decode (active-low, g..a order):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001,
    5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000.
  - Blank = 1111111.
- On capture, legal digit: values slot = digit, blank bit = 0, seen bit set.
- On capture, blank: values slot unchanged, blank bit = 1, seen bit set.
- On capture, any other pattern: error pulses 1 cycle, error_digit = position; slot, blank bit and seen bit unchanged.
- Frame: when seen becomes all 1s, frame_valid pulses on the next cycle and seen clears in that same cycle.
  - A capture coinciding with the clear is kept (seen = that bit only).
- Re-capturing a position already in seen overwrites its slot; seen is unaffected.
- Ghosting during strobe transitions is rejected by the stability requirement.
- Reset asserted mid-window: the window is aborted, and the first capture after release needs a full 2+STABLE_CYCLES clocks.

Test Plan:
1. Reset, then hold digit_n=4'b1110, segments_n=7'b0100100 (STABLE_CYCLES=8):
   - values[3:0]=2 exactly 10 clocks later, blank[0]=0.
   - No second capture while held.
   - frame_valid stays 0.
2. Scan positions 0..3 showing 1,9,0,7, each held 12 cycles:
   - values=16'h7091.
   - frame_valid pulses once, 1 cycle after the last capture.
   - Repeating the scan gives a second pulse.
3. Position 1 pattern held only 5 cycles, then changed:
   - No capture, values unchanged.
   - Glitches between strobes (two strobes low) never capture.
4. Position 2 stable at 7'b0001000 ('A'):
   - error pulses for 1 cycle, error_digit=2.
   - values and seen unchanged; a frame cannot complete until position 2 shows a legal glyph.
5. Position 3 stable at 7'b1111111:
   - blank[3]=1, values[15:12] keeps its previous value, counted toward the frame.
6. Assert reset for 1 cycle mid-scan:
   - All outputs return to reset values.
   - Next capture occurs exactly 2+STABLE_CYCLES clocks after the held input resumes post-reset.

Source files
------------

// File: rtl/seg7_scan_capture.sv
// Recovers BCD digits from a multiplexed, active-low 7-segment display bus.
// Latency 2+STABLE_CYCLES clocks from a steady input to outputs; no backpressure, every qualified pattern is taken.
// Strobe ghosting is filtered by requiring STABLE_CYCLES identical samples before a capture.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [6:0]              segments_n,
  input  logic [NUM_DIGITS-1:0]   digit_n,
  output logic [4*NUM_DIGITS-1:0] values,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    frame_valid,
  output logic                    error,
  output logic [2:0]              error_digit
);

  localparam int          SW      = 7 + NUM_DIGITS;
  localparam logic [7:0]  CNT_MAX = 8'(STABLE_CYCLES);
  localparam logic [7:0]  CNT_HIT = 8'(STABLE_CYCLES - 2);

  typedef struct packed {
    logic       legal;
    logic       is_blank;
    logic [3:0] digit;
  } glyph_t;

  function automatic glyph_t decode_glyph(input logic [6:0] seg);
    glyph_t g;
    g = '{legal: 1'b1, is_blank: 1'b0, digit: 4'd0};
    case (seg)
      7'b1000000: g.digit = 4'd0;
      7'b1111001: g.digit = 4'd1;
      7'b0100100: g.digit = 4'd2;
      7'b0110000: g.digit = 4'd3;
      7'b0011001: g.digit = 4'd4;
      7'b0010010: g.digit = 4'd5;
      7'b0000010: g.digit = 4'd6;
      7'b1111000: g.digit = 4'd7;
      7'b0000000: g.digit = 4'd8;
      7'b0010000: g.digit = 4'd9;
      7'b1111111: begin
        g.legal    = 1'b0;
        g.is_blank = 1'b1;
      end
      default:    g.legal = 1'b0;
    endcase
    return g;
  endfunction

  // Two-flop synchronizer; prev holds the sample before samp for change detection.
  logic [SW-1:0] sync1;
  logic [SW-1:0] samp;
  logic [SW-1:0] prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '1;
      samp  <= '1;
      prev  <= '1;
    end else begin
      sync1 <= {segments_n, digit_n};
      samp  <= sync1;
      prev  <= samp;
    end
  end

  logic [6:0]            seg_s;
  logic [NUM_DIGITS-1:0] sel_oh;
  logic [3:0]            sel_cnt;
  logic [2:0]            sel_idx;
  logic                  sel_valid;
  logic                  changed;

  assign seg_s     = samp[SW-1:NUM_DIGITS];
  assign sel_oh    = ~samp[NUM_DIGITS-1:0];
  assign sel_valid = (sel_cnt == 4'd1);
  assign changed   = (samp != prev);

  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_oh[i]) begin
        sel_cnt = sel_cnt + 4'd1;
        sel_idx = 3'(i);
      end
    end
  end

  logic [7:0] cnt;
  logic       captured;
  logic       cap_evt;

  assign cap_evt = sel_valid && !changed && !captured && (cnt == CNT_HIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= '0;
      captured <= 1'b0;
    end else if (!sel_valid || changed) begin
      cnt      <= '0;
      captured <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
      if (cap_evt) captured <= 1'b1;
    end
  end

  glyph_t                glyph;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_nxt;
  logic                  frame_ready;
  logic                  take;

  assign glyph       = decode_glyph(seg_s);
  assign frame_ready = &seen;
  assign take        = cap_evt && (glyph.legal || glyph.is_blank);

  // The frame clear and a same-cycle capture merge so that capture is not lost.
  always_comb begin
    seen_nxt = frame_ready ? '0 : seen;
    if (take) seen_nxt = seen_nxt | sel_oh;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      values      <= '0;
      blank       <= '1;
      seen        <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
      error_digit <= '0;
    end else begin
      seen        <= seen_nxt;
      frame_valid <= frame_ready;
      error       <= 1'b0;
      if (cap_evt) begin
        if (glyph.legal) begin
          blank <= blank & ~sel_oh;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_oh[i]) values[4*i +: 4] <= glyph.digit;
          end
        end else if (glyph.is_blank) begin
          blank <= blank | sel_oh;
        end else begin
          error       <= 1'b1;
          error_digit <= sel_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture (NUM_DIGITS=4, STABLE_CYCLES=8).
module tb_seg7_scan_capture;

  localparam logic [6:0] SEG0 = 7'b1000000;
  localparam logic [6:0] SEG1 = 7'b1111001;
  localparam logic [6:0] SEG2 = 7'b0100100;
  localparam logic [6:0] SEG3 = 7'b0110000;
  localparam logic [6:0] SEG4 = 7'b0011001;
  localparam logic [6:0] SEG5 = 7'b0010010;
  localparam logic [6:0] SEG6 = 7'b0000010;
  localparam logic [6:0] SEG7 = 7'b1111000;
  localparam logic [6:0] SEG8 = 7'b0000000;
  localparam logic [6:0] SEG9 = 7'b0010000;
  localparam logic [6:0] SEGA = 7'b0001000;
  localparam logic [6:0] SEGB = 7'b1111111;
  localparam logic [3:0] D0 = 4'b1110;
  localparam logic [3:0] D1 = 4'b1101;
  localparam logic [3:0] D2 = 4'b1011;
  localparam logic [3:0] D3 = 4'b0111;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  segments_n;
  logic [3:0]  digit_n;
  logic [15:0] values;
  logic [3:0]  blank;
  logic        frame_valid;
  logic        error;
  logic [2:0]  error_digit;

  int vectors = 0;
  int miscompares = 0;

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(8)) dut (
    .clock(clock), .reset(reset), .segments_n(segments_n), .digit_n(digit_n),
    .values(values), .blank(blank), .frame_valid(frame_valid),
    .error(error), .error_digit(error_digit)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds one bus pattern for n clocks, noting frame/error pulses by clock index.
  task automatic hold(input logic [3:0] dn, input logic [6:0] seg, input int n,
                      output int fv_cnt, output int fv_at, output int er_cnt, output int er_at);
    digit_n = dn;
    segments_n = seg;
    fv_cnt = 0; fv_at = -1; er_cnt = 0; er_at = -1;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (frame_valid) begin fv_cnt++; fv_at = t; end
      if (error) begin er_cnt++; er_at = t; end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (values !== 16'h0000) begin miscompares++; $display("FAIL %s values: got %h want 0000", tag, values); end
    vectors++;
    if (blank !== 4'hF) begin miscompares++; $display("FAIL %s blank: got %b want 1111", tag, blank); end
    vectors++;
    if (frame_valid !== 1'b0) begin miscompares++; $display("FAIL %s frame_valid: got %b want 0", tag, frame_valid); end
    vectors++;
    if (error !== 1'b0) begin miscompares++; $display("FAIL %s error: got %b want 0", tag, error); end
    vectors++;
    if (error_digit !== 3'd0) begin miscompares++; $display("FAIL %s error_digit: got %0d want 0", tag, error_digit); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    segments_n = 7'h7F;
    digit_n = 4'hF;
    tick();
    tick();
    check_reset_outputs("reset");
  endtask

  task automatic test_single_capture();
    int fc, fa, ec, ea;
    reset = 1'b0;
    digit_n = D0;
    segments_n = SEG2;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 9) begin
        vectors++;
        if (values !== 16'h0000) begin miscompares++; $display("FAIL single_early values: got %h want 0000", values); end
      end
    end
    vectors++;
    if (values !== 16'h0002) begin miscompares++; $display("FAIL single_latency values: got %h want 0002", values); end
    vectors++;
    if (blank !== 4'b1110) begin miscompares++; $display("FAIL single_blank: got %b want 1110", blank); end
    hold(D0, SEG2, 20, fc, fa, ec, ea);
    vectors++;
    if (fc !== 0) begin miscompares++; $display("FAIL single_frame count: got %0d want 0", fc); end
    vectors++;
    if (ec !== 0) begin miscompares++; $display("FAIL single_error count: got %0d want 0", ec); end
    vectors++;
    if (values !== 16'h0002) begin miscompares++; $display("FAIL single_held values: got %h want 0002", values); end
  endtask

  task automatic test_scan();
    int fc, fa, ec, ea, fsum, esum;
    for (int pass = 0; pass < 2; pass++) begin
      fsum = 0; esum = 0;
      hold(D0, SEG1, 12, fc, fa, ec, ea); fsum += fc; esum += ec;
      hold(D1, SEG9, 12, fc, fa, ec, ea); fsum += fc; esum += ec;
      hold(D2, SEG0, 12, fc, fa, ec, ea); fsum += fc; esum += ec;
      vectors++;
      if (fsum !== 0) begin miscompares++; $display("FAIL scan%0d early_frame: got %0d want 0", pass, fsum); end
      hold(D3, SEG7, 12, fc, fa, ec, ea); esum += ec;
      vectors++;
      if (fc !== 1) begin miscompares++; $display("FAIL scan%0d frame_count: got %0d want 1", pass, fc); end
      vectors++;
      if (fa !== 11) begin miscompares++; $display("FAIL scan%0d frame_at: got %0d want 11", pass, fa); end
      vectors++;
      if (esum !== 0) begin miscompares++; $display("FAIL scan%0d errors: got %0d want 0", pass, esum); end
      vectors++;
      if (values !== 16'h7091) begin miscompares++; $display("FAIL scan%0d values: got %h want 7091", pass, values); end
    end
  endtask

  task automatic test_short_hold();
    int fc, fa, ec, ea, fsum, esum;
    fsum = 0; esum = 0;
    hold(D1, SEG3, 5, fc, fa, ec, ea); fsum += fc; esum += ec;
    hold(4'b1100, SEG8, 12, fc, fa, ec, ea); fsum += fc; esum += ec;
    hold(4'b0000, SEG4, 12, fc, fa, ec, ea); fsum += fc; esum += ec;
    hold(4'hF, 7'h7F, 12, fc, fa, ec, ea); fsum += fc; esum += ec;
    vectors++;
    if (values !== 16'h7091) begin miscompares++; $display("FAIL short_values: got %h want 7091", values); end
    vectors++;
    if (blank !== 4'b0000) begin miscompares++; $display("FAIL short_blank: got %b want 0000", blank); end
    vectors++;
    if (fsum + esum !== 0) begin miscompares++; $display("FAIL short_pulses: got %0d want 0", fsum + esum); end
  endtask

  task automatic test_illegal();
    int fc, fa, ec, ea, fsum;
    hold(D2, SEGA, 12, fc, fa, ec, ea);
    vectors++;
    if (ec !== 1) begin miscompares++; $display("FAIL illegal_error_count: got %0d want 1", ec); end
    vectors++;
    if (ea !== 10) begin miscompares++; $display("FAIL illegal_error_at: got %0d want 10", ea); end
    vectors++;
    if (error_digit !== 3'd2) begin miscompares++; $display("FAIL illegal_error_digit: got %0d want 2", error_digit); end
    vectors++;
    if (values !== 16'h7091) begin miscompares++; $display("FAIL illegal_values: got %h want 7091", values); end
    fsum = 0;
    hold(D0, SEG4, 12, fc, fa, ec, ea); fsum += fc;
    hold(D1, SEG5, 12, fc, fa, ec, ea); fsum += fc;
    hold(D3, SEG8, 12, fc, fa, ec, ea); fsum += fc;
    vectors++;
    if (fsum !== 0) begin miscompares++; $display("FAIL illegal_no_frame: got %0d want 0", fsum); end
    hold(D2, SEG6, 12, fc, fa, ec, ea);
    vectors++;
    if (fc !== 1 || fa !== 11) begin miscompares++; $display("FAIL illegal_frame: got count %0d at %0d want 1 at 11", fc, fa); end
    vectors++;
    if (values !== 16'h8654) begin miscompares++; $display("FAIL illegal_final_values: got %h want 8654", values); end
    vectors++;
    if (error_digit !== 3'd2) begin miscompares++; $display("FAIL illegal_digit_held: got %0d want 2", error_digit); end
  endtask

  task automatic test_blank();
    int fc, fa, ec, ea, fsum;
    fsum = 0;
    hold(D3, SEGB, 12, fc, fa, ec, ea); fsum += fc;
    vectors++;
    if (blank !== 4'b1000) begin miscompares++; $display("FAIL blank_bit: got %b want 1000", blank); end
    vectors++;
    if (values !== 16'h8654) begin miscompares++; $display("FAIL blank_slot_kept: got %h want 8654", values); end
    hold(D0, SEG2, 12, fc, fa, ec, ea); fsum += fc;
    hold(D1, SEG3, 12, fc, fa, ec, ea); fsum += fc;
    vectors++;
    if (fsum !== 0) begin miscompares++; $display("FAIL blank_early_frame: got %0d want 0", fsum); end
    hold(D2, SEG9, 12, fc, fa, ec, ea);
    vectors++;
    if (fc !== 1 || fa !== 11) begin miscompares++; $display("FAIL blank_frame: got count %0d at %0d want 1 at 11", fc, fa); end
    vectors++;
    if (values !== 16'h8932) begin miscompares++; $display("FAIL blank_values: got %h want 8932", values); end
    vectors++;
    if (ec !== 0) begin miscompares++; $display("FAIL blank_error: got %0d want 0", ec); end
  endtask

  task automatic test_reset_mid();
    digit_n = D0;
    segments_n = SEG5;
    for (int t = 0; t < 6; t++) tick();
    reset = 1'b1;
    tick();
    check_reset_outputs("mid_reset");
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 9) begin
        vectors++;
        if (values !== 16'h0000) begin miscompares++; $display("FAIL mid_early values: got %h want 0000", values); end
      end
    end
    vectors++;
    if (values !== 16'h0005) begin miscompares++; $display("FAIL mid_latency values: got %h want 0005", values); end
    vectors++;
    if (blank !== 4'b1110) begin miscompares++; $display("FAIL mid_blank: got %b want 1110", blank); end
  endtask

  initial begin
    test_reset();
    test_single_capture();
    test_scan();
    test_short_hold();
    test_illegal();
    test_blank();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
